// File: rtl/uart_arb_pkg.sv
// Shared types for the uart_tx arbiter: FSM state encoding and the
// helper that sizes requester-index fields.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    // Width of an index into n requesters (never narrower than one bit).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and uart_tx-side signals of the arbiter.
// slave: the arbiter's view; master: the environment driving it.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import uart_arb_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 start_tx;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic [ID_W-1:0]      grant_id;

    modport slave (
        input  req, req_data, tx_done,
        output ack, done, err, start_tx, tx_data, busy, grant_id
    );

    modport master (
        output req, req_data, tx_done,
        input  ack, done, err, start_tx, tx_data, busy, grant_id
    );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: the requester just after
// last_grant has highest priority, ascending with wrap-around.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               valid
);

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = int'(last_grant) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                winner = idx[ID_W-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte requesters.
// Optional feature: define UART_ARB_TIMEOUT_EN to build a tx_done watchdog
// of TIMEOUT_CYCLES WAIT cycles that aborts the transfer with err.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_chk
        $error("uart_tx_arbiter: NUM_REQ must be within 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               start_tx_q, start_tx_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    pick_winner;
    logic               pick_valid;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Next-state, grant latch and one-cycle status pulses.
    always_comb begin
        state_d      = state_q;
        ack_d        = '0;
        done_d       = '0;
        start_tx_d   = 1'b0;
        tx_data_d    = tx_data_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        err_d        = '0;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d             = ST_LAUNCH;
                    ack_d[pick_winner]  = 1'b1;
                    start_tx_d          = 1'b1;
                    tx_data_d           = bus.req_data[8*int'(pick_winner) +: 8];
                    grant_id_d          = pick_winner;
                    last_grant_d        = pick_winner;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_d               = '0;
`endif
                end
            end
            // tx_done is deliberately not looked at while launching.
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
`ifdef UART_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus.tx_done) begin
                    done_d[grant_id_q] = 1'b1;
                    state_d            = ST_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d[grant_id_q] = 1'b1;
                    state_d           = ST_IDLE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any transfer silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            ack_q        <= '0;
            done_q       <= '0;
            start_tx_q   <= 1'b0;
            tx_data_q    <= '0;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
            err_q        <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            start_tx_q   <= start_tx_d;
            tx_data_q    <= tx_data_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
`ifdef UART_ARB_TIMEOUT_EN
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.done     = done_q;
    assign bus.start_tx = start_tx_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q != ST_IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.err      = err_q;
`else
    assign bus.err      = '0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Timeout expectations switch on UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TO      = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] bytes [4];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bif ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done();
        bif.tx_done = 1'b1;
        step(1);
        bif.tx_done = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        bif.req      = '0;
        bif.req_data = '0;
        bif.tx_done  = 1'b0;

        // Reset state.
        #12;
        check("rst_busy",     32'(bif.busy),     0);
        check("rst_ack",      32'(bif.ack),      0);
        check("rst_done",     32'(bif.done),     0);
        check("rst_err",      32'(bif.err),      0);
        check("rst_start",    32'(bif.start_tx), 0);
        check("rst_tx_data",  32'(bif.tx_data),  0);
        check("rst_grant_id", 32'(bif.grant_id), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(1);
        check("idle_no_req_busy", 32'(bif.busy), 0);

        // Single request from requester 2; tx_done during LAUNCH is ignored.
        bif.req_data = 32'h44A5_2211;
        bif.req      = 4'b0100;
        step(1);
        check("t1_ack",      32'(bif.ack),      32'h4);
        check("t1_start",    32'(bif.start_tx), 1);
        check("t1_tx_data",  32'(bif.tx_data),  32'hA5);
        check("t1_grant_id", 32'(bif.grant_id), 2);
        check("t1_busy",     32'(bif.busy),     1);
        bif.req     = '0;
        bif.tx_done = 1'b1;
        step(1);
        bif.tx_done = 1'b0;
        check("t1_wait_ack",   32'(bif.ack),      0);
        check("t1_wait_start", 32'(bif.start_tx), 0);
        check("t1_launch_ign", 32'(bif.done),     0);
        check("t1_wait_busy",  32'(bif.busy),     1);
        step(2);
        check("t1_hold_data",  32'(bif.tx_data),  32'hA5);
        pulse_done();
        check("t1_done",       32'(bif.done),     32'h4);
        check("t1_done_busy",  32'(bif.busy),     0);
        step(1);
        check("t1_done_clr",   32'(bif.done),     0);

        // Fresh reset, then all four request continuously: 0,1,2,3,0.
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        bif.req_data = 32'h4433_2211;
        bif.req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int g;
            g = k % 4;
            step(1);
            check($sformatf("rr%0d_ack", k),   32'(bif.ack),      32'(1 << g));
            check($sformatf("rr%0d_gid", k),   32'(bif.grant_id), 32'(g));
            check($sformatf("rr%0d_data", k),  32'(bif.tx_data),  32'(bytes[g]));
            check($sformatf("rr%0d_start", k), 32'(bif.start_tx), 1);
            step(1);
            pulse_done();
            check($sformatf("rr%0d_done", k),  32'(bif.done),     32'(1 << g));
            check($sformatf("rr%0d_gap", k),   32'(bif.start_tx), 0);
            check($sformatf("rr%0d_idle", k),  32'(bif.busy),     0);
        end

        // Requester 1 keeps asking, 2 newly asks: 2 must be served before 1.
        bif.req = 4'b0010;
        step(1);
        check("t3_first_gid", 32'(bif.grant_id), 1);
        bif.req = 4'b0110;
        step(1);
        pulse_done();
        check("t3_first_done", 32'(bif.done), 32'h2);
        step(1);
        check("t3_second_ack", 32'(bif.ack),      32'h4);
        check("t3_second_gid", 32'(bif.grant_id), 2);
        bif.req = 4'b0010;
        step(1);
        pulse_done();
        check("t3_second_done", 32'(bif.done), 32'h4);
        step(1);
        check("t3_third_ack", 32'(bif.ack), 32'h2);
        bif.req = '0;
        step(1);
        pulse_done();
        check("t3_third_done", 32'(bif.done), 32'h2);

        // Requester 3 raises and withdraws while 0 is being served.
        bif.req = 4'b0001;
        step(1);
        check("t4_ack0", 32'(bif.ack), 32'h1);
        bif.req = '0;
        step(1);
        bif.req = 4'b1000;
        step(2);
        check("t4_busy_ack", 32'(bif.ack),  0);
        check("t4_busy",     32'(bif.busy), 1);
        bif.req = '0;
        step(1);
        pulse_done();
        check("t4_done0", 32'(bif.done), 32'h1);
        step(3);
        check("t4_no_ack",  32'(bif.ack),  0);
        check("t4_no_done", 32'(bif.done), 0);
        check("t4_no_err",  32'(bif.err),  0);
        check("t4_idle",    32'(bif.busy), 0);

        // Watchdog: no tx_done for 16 WAIT cycles.
        bif.req = 4'b0001;
        step(1);
        check("t5_gid", 32'(bif.grant_id), 0);
        bif.req = '0;
        step(16);
        check("t5_w16_busy", 32'(bif.busy), 1);
        check("t5_w16_err",  32'(bif.err),  0);
        step(1);
`ifdef UART_ARB_TIMEOUT_EN
        check("t5_err",      32'(bif.err),  32'h1);
        check("t5_err_idle", 32'(bif.busy), 0);
        check("t5_err_done", 32'(bif.done), 0);
`else
        check("t5_no_err",   32'(bif.err),  0);
        check("t5_waiting",  32'(bif.busy), 1);
        pulse_done();
        check("t5_late_done", 32'(bif.done), 32'h1);
`endif
        // tx_done in the 16th WAIT cycle resolves as done.
        bif.req = 4'b0001;
        step(1);
        bif.req = '0;
        step(16);
        pulse_done();
        check("t5_tie_done", 32'(bif.done), 32'h1);
        check("t5_tie_err",  32'(bif.err),  0);
        check("t5_tie_idle", 32'(bif.busy), 0);

        // Reset during WAIT clears everything immediately; first grant is 0.
        bif.req = 4'b0100;
        step(1);
        check("t6_gid", 32'(bif.grant_id), 2);
        bif.req = '0;
        step(2);
        check("t6_busy", 32'(bif.busy), 1);
        bif.req = 4'b1111;
        rst     = 1'b0;
        #1;
        check("t6_busy0",  32'(bif.busy),     0);
        check("t6_ack0",   32'(bif.ack),      0);
        check("t6_start0", 32'(bif.start_tx), 0);
        check("t6_data0",  32'(bif.tx_data),  0);
        check("t6_gid0",   32'(bif.grant_id), 0);
        check("t6_done0",  32'(bif.done),     0);
        check("t6_err0",   32'(bif.err),      0);
        step(1);
        pulse_done();
        check("t6_rst_no_done", 32'(bif.done), 0);
        rst = 1'b1;
        step(1);
        check("t6_first_gid", 32'(bif.grant_id), 0);
        check("t6_first_ack", 32'(bif.ack),      32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
